// File: rtl/stft_frame_buffer.sv
// stft_frame_buffer: FFT_SIZE-deep sample ring; each accepted hop pulse replays the last
// FFT_SIZE samples oldest-first over valid/ready while writes continue unstalled.
module stft_frame_buffer #(
  parameter int FFT_SIZE = 256,
  parameter int HOP_SIZE = 128,
  parameter int DATA_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              frame_start_i,
  output logic [DATA_W-1:0] frame_data_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic              frame_first_o,
  output logic              frame_last_o,
  output logic              busy_o,
  output logic              frame_drop_o,
  output logic              overrun_o
);
  localparam int AW = $clog2(FFT_SIZE);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(FFT_SIZE);
  localparam logic [FW-1:0] FULL_M1 = FW'(FFT_SIZE - 1);
  localparam logic [AW-1:0] LAST_CNT = AW'(FFT_SIZE - 1);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, LAST = 2'd2;
  if (HOP_SIZE < 1 || HOP_SIZE > FFT_SIZE) begin : g_bad_hop
    $error("HOP_SIZE must lie in 1..FFT_SIZE");
  end
  logic [DATA_W-1:0] ram [FFT_SIZE];
  logic [DATA_W-1:0] ram_q, data_q, data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d, rd_cnt_q, rd_cnt_d, rd_addr;
  logic [FW-1:0] fill_q, fill_d, wr_since_q, wr_since_d;
  logic [1:0] state_q, state_d;
  logic s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic valid_q, valid_d, first_q, first_d, last_q, last_d, overrun_q, overrun_d;
  logic accept, out_adv, issue, done, unread;
  assign accept  = frame_start_i & sample_valid_i & (state_q == IDLE) & (fill_q >= FULL_M1);
  assign out_adv = ~valid_q | frame_ready_i;
  assign issue   = (state_q == READ) & (~s1_v_q | out_adv);
  assign done    = valid_q & frame_ready_i & last_q;
  assign rd_addr = base_q + rd_cnt_q;
  // a read issued this cycle still sees the old entry, so it counts as already read
  assign unread  = (state_q == READ) & (({1'b0, rd_cnt_q} + FW'(issue)) <= wr_since_q);
  always_comb begin
    wr_ptr_d   = sample_valid_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_d     = (sample_valid_i && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    base_d     = accept ? wr_ptr_q + 1'b1 : base_q;
    rd_cnt_d   = accept ? '0 : issue ? rd_cnt_q + 1'b1 : rd_cnt_q;
    wr_since_d = accept ? '0 : (sample_valid_i && state_q != IDLE) ? wr_since_q + 1'b1 : wr_since_q;
    state_d    = accept ? READ :
                 (issue && rd_cnt_q == LAST_CNT) ? LAST :
                 (state_q == LAST && done) ? IDLE : state_q;
    s1_v_d     = issue | (s1_v_q & ~out_adv);
    s1_first_d = issue ? (rd_cnt_q == '0) : s1_first_q;
    s1_last_d  = issue ? (rd_cnt_q == LAST_CNT) : s1_last_q;
    valid_d    = out_adv ? s1_v_q : valid_q;
    data_d     = (out_adv && s1_v_q) ? ram_q : data_q;
    first_d    = (out_adv && s1_v_q) ? s1_first_q : first_q;
    last_d     = (out_adv && s1_v_q) ? s1_last_q : last_q;
    overrun_d  = overrun_q | (sample_valid_i & unread);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      base_q     <= '0;
      rd_cnt_q   <= '0;
      wr_since_q <= '0;
      state_q    <= IDLE;
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      base_q     <= base_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_since_q <= wr_since_d;
      state_q    <= state_d;
      s1_v_q     <= s1_v_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      first_q    <= first_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
    end
  end
  // RAM is never cleared; fill gating keeps stale entries out of frames
  always_ff @(posedge clk_i) begin
    if (sample_valid_i) ram[wr_ptr_q] <= sample_i;
    if (issue) ram_q <= ram[rd_addr];
  end
  assign frame_data_o  = data_q;
  assign frame_valid_o = valid_q;
  assign frame_first_o = valid_q & first_q;
  assign frame_last_o  = valid_q & last_q;
  assign busy_o        = state_q != IDLE;
  assign frame_drop_o  = frame_start_i & ~accept;
  assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_stft_frame_buffer.sv
// tb_stft_frame_buffer: directed checks of frame replay, priming drops, hop framing,
// backpressure, overrun and mid-frame reset for stft_frame_buffer.
module tb_stft_frame_buffer;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [15:0] sample_i = '0;
  logic sample_valid_i = 1'b0, frame_start_i = 1'b0, frame_ready_i = 1'b1;
  logic [15:0] frame_data_o;
  logic frame_valid_o, frame_first_o, frame_last_o, busy_o, frame_drop_o, overrun_o;
  int n_cmp = 0, n_bad = 0, drops = 0, cyc = 0;
  logic bp = 1'b0;
  logic [3:0] pat = 4'b1001;
  logic [17:0] beats [$];
  logic pv = 1'b0, pr = 1'b0;
  logic [17:0] pd = '0;

  stft_frame_buffer #(.FFT_SIZE(256), .HOP_SIZE(128), .DATA_W(16)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .frame_start_i(frame_start_i), .frame_data_o(frame_data_o), .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i), .frame_first_o(frame_first_o), .frame_last_o(frame_last_o),
    .busy_o(busy_o), .frame_drop_o(frame_drop_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_ni && pv && !pr) begin
      chk("stall_valid", 32'(frame_valid_o), 32'd1);
      chk("stall_hold", 32'({frame_first_o, frame_last_o, frame_data_o}), 32'(pd));
    end
    if (frame_valid_o && frame_ready_i) beats.push_back({frame_first_o, frame_last_o, frame_data_o});
    if (frame_drop_o) drops++;
    pv = reset_ni & frame_valid_o;
    pr = frame_ready_i;
    pd = {frame_first_o, frame_last_o, frame_data_o};
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (bp) frame_ready_i = pat[cyc % 4];
  endtask

  task automatic feed(input logic [15:0] v, input logic st);
    sample_i = v;
    sample_valid_i = 1'b1;
    frame_start_i = st;
    tick();
    sample_valid_i = 1'b0;
    frame_start_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    sample_valid_i = 1'b0;
    frame_start_i = 1'b0;
    tick();
    tick();
    reset_ni = 1'b1;
    beats.delete();
    drops = 0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy_o && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy_o), 32'd0);
    tick();
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_valid", 32'(frame_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    chk("rst_data", 32'(frame_data_o), 0);
    chk("rst_first_last", 32'({frame_first_o, frame_last_o}), 0);
    chk("rst_drop", 32'(frame_drop_o), 0);
    // 1: first full frame, latency and markers
    for (int k = 0; k < 255; k++) feed(16'(k), 1'b0);
    feed(16'd255, 1'b1);
    chk("t1_busy", 32'(busy_o), 1);
    chk("t1_lat0", 32'(frame_valid_o), 0);
    tick();
    chk("t1_lat1", 32'(frame_valid_o), 0);
    tick();
    chk("t1_lat2", 32'(frame_valid_o), 1);
    chk("t1_beat0", 32'({frame_first_o, frame_last_o, frame_data_o}), 32'h20000);
    wait_idle("t1_timeout", 600);
    chk("t1_drop", 32'(drops), 0);
    chk("t1_beats", 32'(beats.size()), 256);
    for (int j = 0; j < 256 && j < beats.size(); j++)
      chk($sformatf("t1_b%0d", j), 32'(beats[j]), {14'd0, j == 0, j == 255, 16'(j)});
    // 2: priming start drops
    do_reset();
    for (int k = 0; k < 127; k++) feed(16'(k), 1'b0);
    feed(16'd127, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    chk("t2_drop", 32'(drops), 1);
    chk("t2_busy", 32'(busy_o), 0);
    chk("t2_beats", 32'(beats.size()), 0);
    // 3: hop every 128 samples, one sample every 3 cycles
    do_reset();
    for (int v = 1; v <= 512; v++) begin
      feed(16'(v), v % 128 == 0);
      tick();
      tick();
    end
    wait_idle("t3_timeout", 600);
    chk("t3_drops", 32'(drops), 1);
    chk("t3_overrun", 32'(overrun_o), 0);
    chk("t3_beats", 32'(beats.size()), 768);
    for (int n = 1; n <= 3; n++)
      for (int j = 0; j < 256; j++)
        if ((n - 1) * 256 + j < beats.size())
          chk($sformatf("t3_f%0d_b%0d", n, j), 32'(beats[(n - 1) * 256 + j]),
              {14'd0, j == 0, j == 255, 16'(128 * n - 127 + j)});
    // 4: backpressure 1,0,0,1
    do_reset();
    for (int k = 0; k < 255; k++) feed(16'(1000 + k), 1'b0);
    bp = 1'b1;
    feed(16'd1255, 1'b1);
    wait_idle("t4_timeout", 2000);
    bp = 1'b0;
    frame_ready_i = 1'b1;
    chk("t4_beats", 32'(beats.size()), 256);
    for (int j = 0; j < 256 && j < beats.size(); j++)
      chk($sformatf("t4_b%0d", j), 32'(beats[j]), {14'd0, j == 0, j == 255, 16'(1000 + j)});
    // 5: stalled frame while writes continue -> sticky overrun
    do_reset();
    for (int k = 0; k < 255; k++) feed(16'(k), 1'b0);
    frame_ready_i = 1'b0;
    feed(16'd255, 1'b1);
    for (int k = 0; k < 300; k++) feed(16'(k), 1'b0);
    chk("t5_overrun_set", 32'(overrun_o), 1);
    frame_ready_i = 1'b1;
    wait_idle("t5_timeout", 600);
    chk("t5_overrun_sticky", 32'(overrun_o), 1);
    chk("t5_beats", 32'(beats.size()), 256);
    // 6: reset at beat 100, then fill gating from empty
    do_reset();
    for (int k = 0; k < 255; k++) feed(16'(k), 1'b0);
    feed(16'd255, 1'b1);
    for (int n = 0; beats.size() < 100 && n < 400; n++) tick();
    chk("t6_reach100", 32'(beats.size()), 100);
    reset_ni = 1'b0;
    tick();
    chk("t6_valid", 32'(frame_valid_o), 0);
    chk("t6_busy", 32'(busy_o), 0);
    chk("t6_overrun", 32'(overrun_o), 0);
    reset_ni = 1'b1;
    beats.delete();
    drops = 0;
    for (int k = 0; k < 199; k++) feed(16'(k), 1'b0);
    feed(16'd199, 1'b1);
    for (int k = 200; k < 254; k++) feed(16'(k), 1'b0);
    feed(16'd254, 1'b1);
    chk("t6_drops", 32'(drops), 2);
    chk("t6_idle", 32'(busy_o), 0);
    chk("t6_nobeats", 32'(beats.size()), 0);
    feed(16'd255, 1'b1);
    chk("t6_accept", 32'(busy_o), 1);
    wait_idle("t6_timeout", 600);
    chk("t6_beats", 32'(beats.size()), 256);
    if (beats.size() == 256) begin
      chk("t6_first", 32'(beats[0]), 32'h20000);
      chk("t6_last", 32'(beats[255]), 32'h100ff);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
